// File: rtl/alu_pkg.sv
// Shared definitions for the ALU control decoder and the execute stage.
// Holds the op code encodings, the execute-queue entry layout and the
// occupancy state encoding of the output queue.
package alu_pkg;

  // Width of the stored result field; the execute stage's DATA_W must not
  // exceed this value.
  localparam int ALU_DATA_W = 32;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef struct packed {
    logic [ALU_DATA_W-1:0] result;
    logic                  zero;
    logic                  illegal;
  } alu_entry_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_e;

endpackage

// File: rtl/alu_exec_stage_core.sv
// alu_core: purely combinational ALU compute.
// Ports:
//   op_code_i  - 4-bit operation from ALU control
//   src_a_i    - operand A
//   src_b_i    - operand B
//   result_o   - computed result (0 for undefined op codes)
//   zero_o     - result is zero (only for legal op codes)
//   illegal_o  - op code is undefined, including codes carrying x/z
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        op_code_i,
  input  logic [DATA_W-1:0] src_a_i,
  input  logic [DATA_W-1:0] src_b_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              illegal_o
);

  logic slt_bit;

  assign slt_bit = ($signed(src_a_i) < $signed(src_b_i));

  // A plain case with a default routes any x/z op code to the illegal arm,
  // since no defined encoding matches an unknown bit exactly.
  always_comb begin
    result_o  = '0;
    illegal_o = 1'b0;
    case (op_code_i)
      ALU_ADD: result_o = src_a_i + src_b_i;
      ALU_SUB: result_o = src_a_i - src_b_i;
      ALU_AND: result_o = src_a_i & src_b_i;
      ALU_OR:  result_o = src_a_i | src_b_i;
      ALU_SLT: result_o = {{(DATA_W-1){1'b0}}, slt_bit};
      default: illegal_o = 1'b1;
    endcase
  end

  assign zero_o = !illegal_o && (result_o == '0);

endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute stage behind the ALU control decoder.
// Computes result/zero/illegal on accept and buffers them in a 2-entry FIFO
// with valid/ready handshakes on both sides; counts accepted illegal ops.
// Ports:
//   clk, rst_n          - clock, async active-low reset
//   in_valid / in_ready - input handshake (in_ready from registered state only)
//   op_code, src_a, src_b - operation and operands, sampled on accept
//   out_valid / out_ready - output handshake
//   result, zero, illegal - head entry of the queue
//   illegal_cnt         - saturating count of accepted illegal ops
//
// state     | meaning
// OCC_EMPTY | no entries queued, out_valid low
// OCC_ONE   | one entry queued, can push and pop in the same cycle
// OCC_FULL  | two entries queued, in_ready low
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op_code,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              illegal,
  output logic [CNT_W-1:0]  illegal_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  occ_state_e       state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  alu_entry_t       mem_q [2];
  alu_entry_t       entry_d;
  alu_entry_t       head;

  logic [DATA_W-1:0] core_result;
  logic              core_zero;
  logic              core_illegal;
  logic              push;
  logic              pop;

  alu_core #(.DATA_W(DATA_W)) u_core (
    .op_code_i (op_code),
    .src_a_i   (src_a),
    .src_b_i   (src_b),
    .result_o  (core_result),
    .zero_o    (core_zero),
    .illegal_o (core_illegal)
  );

  assign push = in_valid && in_ready_q;
  assign pop  = out_valid_q && out_ready;

  always_comb begin
    entry_d         = '0;
    entry_d.result  = ALU_DATA_W'(core_result);
    entry_d.zero    = core_zero;
    entry_d.illegal = core_illegal;
  end

  // Occupancy FSM; in_ready/out_valid are registered alongside the state so
  // neither handshake output has a combinational path from the other side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= OCC_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        OCC_EMPTY: begin
          if (push) begin
            state_q     <= OCC_ONE;
            out_valid_q <= 1'b1;
          end
        end
        OCC_ONE: begin
          if (push && !pop) begin
            state_q    <= OCC_FULL;
            in_ready_q <= 1'b0;
          end else if (pop && !push) begin
            state_q     <= OCC_EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        OCC_FULL: begin
          if (pop) begin
            state_q    <= OCC_ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= OCC_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    cnt_d    = cnt_q;
    if (push && core_illegal && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push) begin
        mem_q[wr_ptr_q] <= entry_d;
      end
    end
  end

  assign head        = mem_q[rd_ptr_q];
  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign result      = head.result[DATA_W-1:0];
  assign zero        = head.zero;
  assign illegal     = head.illegal;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
module tb_alu_exec_stage;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        illegal;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [3:0]  op_code;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [31:0] result;
  logic        zero;
  logic        illegal;
  logic [7:0]  illegal_cnt;

  logic        s_in_ready;
  logic        s_out_valid;
  logic [31:0] s_result;
  logic        s_zero;
  logic        s_illegal;
  logic [1:0]  s_illegal_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t sb[$];
  int exp_cnt     = 0;
  int exp_cnt_sat = 0;
  logic [3:0] zprobe;
  logic zsup;

  alu_exec_stage #(.DATA_W(32), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_code(op_code), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  alu_exec_stage #(.DATA_W(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .op_code(op_code), .src_a(src_a), .src_b(src_b),
    .out_valid(s_out_valid), .out_ready(out_ready), .result(s_result),
    .zero(s_zero), .illegal(s_illegal), .illegal_cnt(s_illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e = '0;
    if ($isunknown(op)) begin
      e.illegal = 1'b1;
    end else begin
      case (op)
        4'b0010: e.result = a + b;
        4'b0110: e.result = a - b;
        4'b0000: e.result = a & b;
        4'b0001: e.result = a | b;
        4'b0111: e.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        default: e.illegal = 1'b1;
      endcase
    end
    if (!e.illegal) e.zero = (e.result == 32'd0);
    return e;
  endfunction

  // Scoreboard monitor: sampled on the falling edge, between driving and accepting edges.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      exp_cnt = 0;
      exp_cnt_sat = 0;
    end else begin
      n_checks++;
      if (out_valid !== (sb.size() != 0)) begin
        n_fail++;
        $display("FAIL occ_out_valid: got %b expected %b", out_valid, (sb.size() != 0));
      end
      n_checks++;
      if (in_ready !== (sb.size() < 2)) begin
        n_fail++;
        $display("FAIL occ_in_ready: got %b expected %b", in_ready, (sb.size() < 2));
      end
      n_checks++;
      if (illegal_cnt !== exp_cnt[7:0]) begin
        n_fail++;
        $display("FAIL illegal_cnt: got %0d expected %0d", illegal_cnt, exp_cnt);
      end
      n_checks++;
      if (s_illegal_cnt !== exp_cnt_sat[1:0]) begin
        n_fail++;
        $display("FAIL illegal_cnt_sat: got %0d expected %0d", s_illegal_cnt, exp_cnt_sat);
      end
      if (out_valid === 1'b1 && out_ready === 1'b1 && sb.size() != 0) begin
        e = sb.pop_front();
        n_checks++;
        if ({result, zero, illegal} !== {e.result, e.zero, e.illegal}) begin
          n_fail++;
          $display("FAIL head_entry: got result=%h zero=%b illegal=%b expected result=%h zero=%b illegal=%b",
                   result, zero, illegal, e.result, e.zero, e.illegal);
        end
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        e = model(op_code, src_a, src_b);
        sb.push_back(e);
        if (e.illegal) begin
          if (exp_cnt != 255) exp_cnt++;
          if (exp_cnt_sat != 3) exp_cnt_sat++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    op_code = op;
    src_a = a;
    src_b = b;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = (in_ready === 1'b1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed %b, expected 1 within 50 cycles", in_ready);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    op_code = 4'b0000;
    src_a = '0;
    src_b = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({out_valid, result, zero, illegal, illegal_cnt} !== 42'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b result=%h zero=%b illegal=%b cnt=%0d expected all 0",
               out_valid, result, zero, illegal, illegal_cnt);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    // Fill both entries (one illegal), then reset mid-stream.
    @(posedge clk);
    #1;
    send(4'b1111, 32'd3, 32'd4);
    send(4'b0010, 32'd1, 32'd2);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || illegal_cnt !== 8'd0 || result !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_midstream: got valid=%b cnt=%0d result=%h expected 0/0/0",
               out_valid, illegal_cnt, result);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_no_stale: got valid=%b ready=%b expected 0/1", out_valid, in_ready);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_arith();
    out_ready = 1'b1;
    send(4'b0010, 32'hFFFF_FFFF, 32'd1);
    send(4'b0110, 32'd5, 32'd7);
    send(4'b0000, 32'h0000_F0F0, 32'h0000_0FF0);
    send(4'b0001, 32'h0000_F000, 32'h0000_000F);
    @(negedge clk);
    n_checks++;
    if (result !== 32'h0000_F00F || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL arith_last_head: got valid=%b result=%h expected 1/0000f00f", out_valid, result);
    end
    idle(3);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL arith_drain: got %0d entries outstanding expected 0", sb.size());
    end
  endtask

  task automatic test_slt();
    out_ready = 1'b1;
    send(4'b0111, 32'hFFFF_FFFF, 32'd1);
    @(negedge clk);
    n_checks++;
    if (result !== 32'd1 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL slt_neg_lt_pos: got result=%h zero=%b expected 1/0", result, zero);
    end
    @(posedge clk);
    #1;
    send(4'b0111, 32'd1, 32'hFFFF_FFFF);
    @(negedge clk);
    n_checks++;
    if (result !== 32'd0 || zero !== 1'b1) begin
      n_fail++;
      $display("FAIL slt_pos_lt_neg: got result=%h zero=%b expected 0/1", result, zero);
    end
    idle(3);
  endtask

  task automatic test_backpressure();
    bit ok;
    out_ready = 1'b0;
    send(4'b0010, 32'd10, 32'd1);
    send(4'b0010, 32'd20, 32'd2);
    in_valid = 1'b1;
    op_code = 4'b0010;
    src_a = 32'd30;
    src_b = 32'd3;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== 32'd11) begin
        n_fail++;
        $display("FAIL bp_hold: got ready=%b valid=%b result=%h expected 0/1/0000000b",
                 in_ready, out_valid, result);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = (in_ready === 1'b1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL bp_third_accept: in_ready got %b expected 1 after release", in_ready);
    end
    idle(4);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL bp_drain: got %0d entries outstanding expected 0", sb.size());
    end
  endtask

  task automatic test_illegal();
    out_ready = 1'b0;
    send(4'b1111, 32'd5, 32'd6);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || result !== 32'd0 || zero !== 1'b0 || illegal !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_head: got valid=%b result=%h zero=%b illegal=%b expected 1/0/0/1",
               out_valid, result, zero, illegal);
    end
    @(posedge clk);
    #1;
    send(4'bzzzz, 32'h0000_0007, 32'h0000_000C);
    out_ready = 1'b1;
    idle(4);
    // A two-state simulator collapses z to 0, which the decoder then sees as AND.
    n_checks++;
    if (illegal_cnt !== (zsup ? 8'd2 : 8'd1)) begin
      n_fail++;
      $display("FAIL illegal_count: got %0d expected %0d", illegal_cnt, (zsup ? 2 : 1));
    end
    do_reset();
    out_ready = 1'b1;
    repeat (5) send(4'b1111, 32'd1, 32'd1);
    idle(3);
    n_checks++;
    if (illegal_cnt !== 8'd5 || s_illegal_cnt !== 2'd3) begin
      n_fail++;
      $display("FAIL illegal_saturate: got cnt8=%0d cnt2=%0d expected 5/3", illegal_cnt, s_illegal_cnt);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    send(4'b0010, 32'd100, 32'd0);
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      op_code = 4'b0010;
      src_a = 32'd200 + 32'(i);
      src_b = 32'd1;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_occ_one: cycle %0d got ready=%b valid=%b expected 1/1", i, in_ready, out_valid);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    idle(3);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_drain: got %0d entries outstanding expected 0", sb.size());
    end
  endtask

  initial begin
    zprobe = 4'bzzzz;
    zsup = $isunknown(zprobe);
    test_reset();
    test_arith();
    test_slt();
    test_backpressure();
    test_illegal();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
